// File: rtl/codix_risc_ca_core_regs_rf_pkg.sv
// Shared sizing and types for the codix_risc_ca core register file.
// Modules take their parameter defaults from here.
package codix_risc_ca_core_regs_rf_pkg;

    localparam int REGS_DATA_W = 32;
    localparam int REGS_ADDR_W = 5;
    localparam int DEPTH       = 2 ** REGS_ADDR_W;

    typedef logic [REGS_DATA_W-1:0] regs_word_t;
    typedef logic [REGS_ADDR_W-1:0] regs_addr_t;

endpackage

// File: rtl/codix_risc_ca_core_regs_rport.sv
// One registered read port of the register file.
// Output holds while disabled, r0 masks to zero, and a same-edge write can be forwarded.
module codix_risc_ca_core_regs_rport
    import codix_risc_ca_core_regs_rf_pkg::*;
#(
    parameter int DATA_W   = REGS_DATA_W,
    parameter int ADDR_W   = REGS_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;
    logic              zero_hit;
    logic              bypass_hit;

    // Zero masking outranks forwarding, so a dropped r0 write never reaches q.
    always_comb begin
        zero_hit   = (ZERO_REG != 0) && (ra == '0);
        bypass_hit = (BYPASS != 0) && wr_en && (wr_addr == ra);
        q_d        = q_q;
        if (re) begin
            if (zero_hit) begin
                q_d = '0;
            end else if (bypass_hit) begin
                q_d = wr_data;
            end else begin
                q_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/codix_risc_ca_core_regs_rf.sv
// 32 x 32-bit general-purpose register file: three registered read ports and one
// synchronous write port, asynchronously cleared by RST.
module codix_risc_ca_core_regs_rf
    import codix_risc_ca_core_regs_rf_pkg::*;
#(
    parameter int DATA_W   = REGS_DATA_W,
    parameter int ADDR_W   = REGS_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] RA0,
    input  logic              RE0,
    output logic [DATA_W-1:0] Q0,
    input  logic [ADDR_W-1:0] RA1,
    input  logic              RE1,
    output logic [DATA_W-1:0] Q1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic              RE2,
    output logic [DATA_W-1:0] Q2,
    input  logic [DATA_W-1:0] D0,
    input  logic [ADDR_W-1:0] WA0,
    input  logic              WE0
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic              wr_ok;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    // Writes to r0 are discarded when it is hardwired to zero.
    always_comb begin
        wr_ok = WE0 && !((ZERO_REG != 0) && (WA0 == '0));
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[WA0] = D0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata0 = mem_q[RA0];
    assign rdata1 = mem_q[RA1];
    assign rdata2 = mem_q[RA2];

    codix_risc_ca_core_regs_rport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_rport0 (
        .clk      (CLK),
        .rst      (RST),
        .re       (RE0),
        .ra       (RA0),
        .mem_rdata(rdata0),
        .wr_en    (wr_ok),
        .wr_addr  (WA0),
        .wr_data  (D0),
        .q        (Q0)
    );

    codix_risc_ca_core_regs_rport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_rport1 (
        .clk      (CLK),
        .rst      (RST),
        .re       (RE1),
        .ra       (RA1),
        .mem_rdata(rdata1),
        .wr_en    (wr_ok),
        .wr_addr  (WA0),
        .wr_data  (D0),
        .q        (Q1)
    );

    codix_risc_ca_core_regs_rport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_rport2 (
        .clk      (CLK),
        .rst      (RST),
        .re       (RE2),
        .ra       (RA2),
        .mem_rdata(rdata2),
        .wr_en    (wr_ok),
        .wr_addr  (WA0),
        .wr_data  (D0),
        .q        (Q2)
    );

endmodule

// File: tb/tb_codix_risc_ca_core_regs_rf.sv
// Bench for the register file: a write-first instance and a read-old instance
// share all inputs and are checked against directed vectors and an array model.
`timescale 1ns/1ps
module tb_codix_risc_ca_core_regs_rf;
    import codix_risc_ca_core_regs_rf_pkg::*;

    typedef struct packed {
        logic       we;
        regs_addr_t wa;
        regs_word_t d;
        logic       re0;
        regs_addr_t ra0;
        logic       re1;
        regs_addr_t ra1;
        logic       re2;
        regs_addr_t ra2;
    } stim_t;

    typedef struct {
        stim_t      s;
        regs_word_t e [3];
        regs_word_t n [3];
    } vec_t;

    logic       clk;
    logic       rst;
    regs_addr_t ra0, ra1, ra2, wa0;
    logic       re0, re1, re2, we0;
    regs_word_t d0;
    regs_word_t q0, q1, q2;
    regs_word_t q0_nb, q1_nb, q2_nb;

    int n_cmp;
    int n_fail;

    regs_word_t model_mem [DEPTH];
    regs_word_t model_q   [3];
    regs_word_t model_qn  [3];

    vec_t vecs [11];

    codix_risc_ca_core_regs_rf #(.BYPASS(1)) dut (
        .CLK(clk), .RST(rst),
        .RA0(ra0), .RE0(re0), .Q0(q0),
        .RA1(ra1), .RE1(re1), .Q1(q1),
        .RA2(ra2), .RE2(re2), .Q2(q2),
        .D0(d0), .WA0(wa0), .WE0(we0)
    );

    codix_risc_ca_core_regs_rf #(.BYPASS(0)) dut_nb (
        .CLK(clk), .RST(rst),
        .RA0(ra0), .RE0(re0), .Q0(q0_nb),
        .RA1(ra1), .RE1(re1), .Q1(q1_nb),
        .RA2(ra2), .RE2(re2), .Q2(q2_nb),
        .D0(d0), .WA0(wa0), .WE0(we0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(
        input logic we, input int wa, input regs_word_t d,
        input logic r0, input int a0, input logic r1, input int a1,
        input logic r2, input int a2,
        input regs_word_t e0, input regs_word_t e1, input regs_word_t e2,
        input regs_word_t n0, input regs_word_t n1, input regs_word_t n2);
        vec_t v;
        v.s.we  = we;
        v.s.wa  = regs_addr_t'(wa);
        v.s.d   = d;
        v.s.re0 = r0;
        v.s.ra0 = regs_addr_t'(a0);
        v.s.re1 = r1;
        v.s.ra1 = regs_addr_t'(a1);
        v.s.re2 = r2;
        v.s.ra2 = regs_addr_t'(a2);
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
        v.n[0] = n0; v.n[1] = n1; v.n[2] = n2;
        return v;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Reference: reads see the array as it stood before this edge, except that the
    // write-first variant sees the incoming data on a matching non-zero address.
    task automatic modelEdge(input stim_t s);
        logic       re [3];
        regs_addr_t ra [3];
        re[0] = s.re0; re[1] = s.re1; re[2] = s.re2;
        ra[0] = s.ra0; ra[1] = s.ra1; ra[2] = s.ra2;
        for (int i = 0; i < 3; i++) begin
            if (re[i]) begin
                if (ra[i] == 0) begin
                    model_q[i]  = 0;
                    model_qn[i] = 0;
                end else begin
                    model_q[i]  = (s.we && s.wa == ra[i]) ? s.d : model_mem[ra[i]];
                    model_qn[i] = model_mem[ra[i]];
                end
            end
        end
        if (s.we && s.wa != 0) model_mem[s.wa] = s.d;
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        for (int i = 0; i < 3; i++) begin
            model_q[i]  = 0;
            model_qn[i] = 0;
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        we0 = s.we;  wa0 = s.wa;  d0 = s.d;
        re0 = s.re0; ra0 = s.ra0;
        re1 = s.re1; ra1 = s.ra1;
        re2 = s.re2; ra2 = s.ra2;
        @(posedge clk);
        modelEdge(s);
        #1;
    endtask

    task automatic checkOutput(input string name, input regs_word_t act, input regs_word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, " q0"},    q0,    model_q[0]);
        checkOutput({tag, " q1"},    q1,    model_q[1]);
        checkOutput({tag, " q2"},    q2,    model_q[2]);
        checkOutput({tag, " q0_nb"}, q0_nb, model_qn[0]);
        checkOutput({tag, " q1_nb"}, q1_nb, model_qn[1]);
        checkOutput({tag, " q2_nb"}, q2_nb, model_qn[2]);
    endtask

    initial begin
        stim_t s;
        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, 5, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 0, 32'h12345678, 1, 0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0);
        vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0);
        vecs[4]  = mk(1, 7, 32'h11111111, 0, 0, 0, 0, 0, 0,
                      0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0);
        vecs[5]  = mk(1, 7, 32'h22222222, 0, 0, 0, 0, 1, 7,
                      0, 32'hDEADBEEF, 32'h22222222, 0, 32'hDEADBEEF, 32'h11111111);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 7,
                      0, 32'hDEADBEEF, 32'h22222222, 0, 32'hDEADBEEF, 32'h22222222);
        vecs[7]  = mk(1, 9, 32'hA5A5A5A5, 1, 5, 0, 0, 0, 0,
                      32'hDEADBEEF, 32'hDEADBEEF, 32'h22222222,
                      32'hDEADBEEF, 32'hDEADBEEF, 32'h22222222);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1, 9, 0, 0,
                      32'hDEADBEEF, 32'hA5A5A5A5, 32'h22222222,
                      32'hDEADBEEF, 32'hA5A5A5A5, 32'h22222222);
        vecs[9]  = mk(0, 0, 0, 1, 7, 1, 7, 1, 7,
                      32'h22222222, 32'h22222222, 32'h22222222,
                      32'h22222222, 32'h22222222, 32'h22222222);
        vecs[10] = mk(1, 9, 32'h0BADF00D, 1, 9, 1, 9, 0, 0,
                      32'h0BADF00D, 32'h0BADF00D, 32'h22222222,
                      32'hA5A5A5A5, 32'hA5A5A5A5, 32'h22222222);

        // Reset held for two edges, then every address read on all ports.
        rst = 1'b0;
        s = idle();
        we0 = 0; wa0 = 0; d0 = 0;
        re0 = 0; ra0 = 0; re1 = 0; ra1 = 0; re2 = 0; ra2 = 0;
        #1 rst = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset q0", q0, 0);
        checkOutput("reset q1", q1, 0);
        checkOutput("reset q2", q2, 0);
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            s = idle();
            s.re0 = 1; s.ra0 = regs_addr_t'(a);
            s.re1 = 1; s.ra1 = regs_addr_t'(a);
            s.re2 = 1; s.ra2 = regs_addr_t'(a);
            applyStimulus(s);
            checkOutput($sformatf("clear r%0d q0", a), q0, 0);
            checkOutput($sformatf("clear r%0d q1", a), q1, 0);
            checkOutput($sformatf("clear r%0d q2", a), q2, 0);
        end

        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].s);
            checkOutput($sformatf("vec%0d q0", v),    q0,    vecs[v].e[0]);
            checkOutput($sformatf("vec%0d q1", v),    q1,    vecs[v].e[1]);
            checkOutput($sformatf("vec%0d q2", v),    q2,    vecs[v].e[2]);
            checkOutput($sformatf("vec%0d q0_nb", v), q0_nb, vecs[v].n[0]);
            checkOutput($sformatf("vec%0d q1_nb", v), q1_nb, vecs[v].n[1]);
            checkOutput($sformatf("vec%0d q2_nb", v), q2_nb, vecs[v].n[2]);
        end

        // Enable hold: Q1 must keep its value while RE1 is low, whatever RA1 and writes do.
        s = idle();
        s.we = 1; s.wa = 12; s.d = 32'hA5A5A5A5;
        applyStimulus(s);
        s = idle();
        s.re1 = 1; s.ra1 = 12;
        applyStimulus(s);
        checkOutput("hold load q1", q1, 32'hA5A5A5A5);
        for (int c = 0; c < 10; c++) begin
            s = idle();
            s.ra1 = (c % 2 == 0) ? regs_addr_t'(12) : regs_addr_t'($urandom_range(0, 31));
            s.we = 1; s.wa = 12; s.d = $urandom;
            applyStimulus(s);
            checkOutput($sformatf("hold c%0d q1", c), q1, 32'hA5A5A5A5);
        end

        // Random traffic on a narrow address range to provoke collisions and r0 hits.
        for (int it = 0; it < 400; it++) begin
            s.we  = $urandom_range(0, 1);
            s.wa  = regs_addr_t'($urandom_range(0, 7));
            s.d   = $urandom;
            s.re0 = $urandom_range(0, 1);
            s.ra0 = regs_addr_t'($urandom_range(0, 7));
            s.re1 = $urandom_range(0, 1);
            s.ra1 = regs_addr_t'($urandom_range(0, 7));
            s.re2 = $urandom_range(0, 1);
            s.ra2 = regs_addr_t'($urandom_range(0, 7));
            applyStimulus(s);
            checkAgainstModel($sformatf("rand%0d", it));
        end

        // Reset asserted between edges must clear outputs at once and wipe the array.
        s = idle();
        s.we = 1; s.wa = 3; s.d = 32'h55AA55AA;
        applyStimulus(s);
        s = idle();
        s.re0 = 1; s.ra0 = 3; s.re1 = 1; s.ra1 = 3; s.re2 = 1; s.ra2 = 3;
        applyStimulus(s);
        checkOutput("pre-reset q0", q0, 32'h55AA55AA);
        checkOutput("pre-reset q2_nb", q2_nb, 32'h55AA55AA);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async reset q0", q0, 0);
        checkOutput("async reset q1", q1, 0);
        checkOutput("async reset q2", q2, 0);
        checkOutput("async reset q0_nb", q0_nb, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        s = idle();
        s.re0 = 1; s.ra0 = 3; s.re1 = 1; s.ra1 = 5;
        applyStimulus(s);
        checkOutput("post-reset r3 q0", q0, 0);
        checkOutput("post-reset r5 q1", q1, 0);
        checkAgainstModel("post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/codix_risc_ca_core_regs_rf.md
Name: codix_risc_ca_core_regs_rf

Overview:
RTL register file behind the regs_t interface (DUT side): 32 x 32-bit general-purpose registers, three read ports, one write port. Reads are registered and take 1 cycle; the write is synchronous. Instantiated in the codix_risc_ca core and driven by the decode/writeback stages. The regs_t monitor agent observes it.

Parameters:
DATA_W, 32, register and port data width
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
BYPASS, 1, 1 = a write in the same cycle is forwarded to a read of the same address (write-first); 0 = the read returns the old value

Ports:
CLK  in  1  clock; all state changes on posedge
RST  in  1  reset; asynchronous, active-high
RA0  in  ADDR_W  read port 0 address
RE0  in  1  read port 0 enable
Q0   out DATA_W  read port 0 data (registered)
RA1  in  ADDR_W  read port 1 address
RE1  in  1  read port 1 enable
Q1   out DATA_W  read port 1 data (registered)
RA2  in  ADDR_W  read port 2 address
RE2  in  1  read port 2 enable
Q2   out DATA_W  read port 2 data (registered)
D0   in  DATA_W  write data
WA0  in  ADDR_W  write address
WE0  in  1  write enable

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST is asynchronous and active-high.
  - While RST=1: all registers = 0; Q0, Q1, Q2 = 0, immediately and not waiting for a clock edge.
  - The first posedge after RST falls operates normally.
  - RST asserted mid-operation: any write at a coinciding edge is lost; the array and outputs are cleared.
- Write:
  - At posedge, if WE0=1, then mem[WA0] <= D0.
  - If ZERO_REG=1 and WA0=0, the write is dropped.
  - WE0=0: D0 and WA0 are ignored, including X values.
- Read (each port i independent):
  - At posedge, if REi=1, then Qi <= value of mem[RAi]. Latency is 1 cycle: Qi is valid in the cycle after the RE/RA sample.
  - REi=0: Qi holds its last value. RAi is ignored, including X values.
  - ZERO_REG=1 and RAi=0: Qi <= 0 regardless of mem contents or bypass.
- Read/write collision (same edge, WE0=1, REi=1, RAi=WA0, address not a dropped zero-register write):
  - BYPASS=1: Qi <= D0.
  - BYPASS=0: Qi <= previous mem[RAi].
  - The next read of that address returns D0 in both modes.
- Multiple read ports may use the same address in the same cycle; all receive identical data.
- No X propagation on Q when every enabled address is known.
- No handshake or back-pressure; every cycle accepts new requests.

Decomposition:
- Package codix_risc_ca_core_regs_rf_pkg holds:
  - DATA_W and ADDR_W defaults
  - DEPTH constant
  - typedefs regs_word_t (logic [DATA_W-1:0]) and regs_addr_t (logic [ADDR_W-1:0])
- Sub-module codix_risc_ca_core_regs_rport: one registered read port containing enable-hold, zero-register masking and the bypass mux. It is instantiated 3x.
- The top module owns the storage array and the write logic.

Test Plan:
- Reset clear: RST=1 for 2 cycles, then read all 32 addresses on ports 0/1/2 -> every Q = 0x00000000; Q = 0 asynchronously during RST.
- Write/read latency: write WA0=5, D0=0xDEADBEEF; next cycle RA1=5, RE1=1 -> Q1 = 0xDEADBEEF exactly one edge later; Q0 and Q2 unchanged.
- Zero register: write WA0=0, D0=0x12345678, while RA0=0 and RE0=1 in the same and the following cycle -> Q0 = 0 both times (ZERO_REG=1).
- Collision bypass:
  - BYPASS=1: preload r7=0x11111111; in one cycle WE0=1, WA0=7, D0=0x22222222, RA2=7, RE2=1 -> Q2 = 0x22222222.
  - BYPASS=0 build: same stimulus -> Q2 = 0x11111111, then 0x22222222 on the next read.
- Enable hold: Q1 = 0xA5A5A5A5 after a read; hold RE1=0 with RA1 toggling across 10 cycles and writes to that address -> Q1 stays 0xA5A5A5A5.
- Reset mid-operation: write r3=0x55AA55AA, then assert RST asynchronously between edges -> Q0..Q2 = 0 immediately; after release, a read of r3 returns 0.
